// File: rtl/rip_const.sv
// Shared constants and types for the rip memory subsystem.
package rip_const;
  localparam int B_WIDTH = 8;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_W_ISSUE,
    ARB_W_WAIT,
    ARB_R_ISSUE,
    ARB_R_WAIT
  } arb_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rip_round_robin_arbiter.sv
// Combinational round-robin pick: first requester after i_last_grant, wrapping.
module rip_round_robin_arbiter
  import rip_const::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [IDX_W-1:0]     i_last_grant,
  output logic [NUM_PORTS-1:0] o_grant_oh,
  output logic [IDX_W-1:0]     o_grant_idx,
  output logic                 o_any
);
  always_comb begin
    int p;
    logic [IDX_W-1:0] w_pi;
    o_grant_oh  = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    p           = 0;
    w_pi        = '0;
    // Walk farthest-first so the nearest pending port after last_grant wins.
    for (int k = NUM_PORTS; k >= 1; k--) begin
      p = int'(i_last_grant) + k;
      if (p >= NUM_PORTS) p = p - NUM_PORTS;
      w_pi = IDX_W'(p);
      if (i_req[w_pi]) begin
        o_grant_oh       = '0;
        o_grant_oh[w_pi] = 1'b1;
        o_grant_idx      = w_pi;
        o_any            = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rip_memory_port_arbiter.sv
// N-port round-robin front end serialising byte-addressed loads/stores onto
// the line-granular rip_axi_master request interface, one transaction at a time.
module rip_memory_port_arbiter
  import rip_const::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_SIZE  = 4
) (
  input  logic                                         i_clk,
  input  logic                                         i_rstn,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH/B_WIDTH-1:0] i_we,
  input  logic [NUM_PORTS-1:0]                         i_re,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]         i_addr,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]         i_din,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]         o_dout,
  output logic [NUM_PORTS-1:0]                         o_busy,
  output logic [ADDR_WIDTH-1:0]                        o_waddr,
  output logic [LINE_SIZE*B_WIDTH-1:0]                 o_wdata,
  output logic [LINE_SIZE-1:0]                         o_wstrb,
  output logic                                         o_wvalid,
  input  logic                                         i_wready,
  input  logic                                         i_wdone,
  output logic [ADDR_WIDTH-1:0]                        o_raddr,
  output logic                                         o_rvalid,
  input  logic                                         i_rready,
  input  logic [LINE_SIZE*B_WIDTH-1:0]                 i_rdata,
  input  logic                                         i_rdone
);
  localparam int BPW    = DATA_WIDTH / B_WIDTH;
  localparam int LINE_W = LINE_SIZE * B_WIDTH;
  localparam int IDX_W  = idx_width(NUM_PORTS);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(LINE_SIZE - 1);

  // Word index of a byte address within its line; sub-word bits drop out.
  function automatic int word_off(input logic [ADDR_WIDTH-1:0] a);
    return int'((a & OFF_MASK) >> $clog2(BPW));
  endfunction

  logic [NUM_PORTS-1:0]                 r_busy, r_pend, r_kind_wr;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] r_addr;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] r_din, r_dout;
  logic [NUM_PORTS-1:0][BPW-1:0]        r_we;

  arb_state_e          r_state, w_next;
  logic [IDX_W-1:0]    r_grant, r_last;
  logic [ADDR_WIDTH-1:0] r_waddr, r_raddr;
  logic [LINE_W-1:0]   r_wdata;
  logic [LINE_SIZE-1:0] r_wstrb;
  logic                r_wvalid, r_rvalid;

  logic [NUM_PORTS-1:0]  w_gnt_oh;
  logic [IDX_W-1:0]      w_gnt_idx;
  logic                  w_gnt_any, w_start, w_fin;
  logic [ADDR_WIDTH-1:0] w_sel_addr, w_line;
  logic [LINE_W-1:0]     w_wdata;
  logic [LINE_SIZE-1:0]  w_wstrb;
  logic [DATA_WIDTH-1:0] w_rword;

  rip_round_robin_arbiter #(.NUM_PORTS(NUM_PORTS), .IDX_W(IDX_W)) u_rr (
    .i_req       (r_pend),
    .i_last_grant(r_last),
    .o_grant_oh  (w_gnt_oh),
    .o_grant_idx (w_gnt_idx),
    .o_any       (w_gnt_any)
  );

  assign w_start    = (r_state == ARB_IDLE) && w_gnt_any;
  assign w_fin      = ((r_state == ARB_W_WAIT) && i_wdone) || ((r_state == ARB_R_WAIT) && i_rdone);
  assign w_sel_addr = r_addr[w_gnt_idx];
  assign w_line     = w_sel_addr & ~OFF_MASK;
  assign w_wdata    = LINE_W'(r_din[w_gnt_idx]) << (word_off(w_sel_addr) * DATA_WIDTH);
  assign w_wstrb    = LINE_SIZE'(r_we[w_gnt_idx]) << (word_off(w_sel_addr) * BPW);
  assign w_rword    = DATA_WIDTH'(i_rdata >> (word_off(r_addr[r_grant]) * DATA_WIDTH));

  always_ff @(posedge i_clk) begin
    if (!i_rstn) r_state <= ARB_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ARB_IDLE:    if (w_gnt_any) w_next = r_kind_wr[w_gnt_idx] ? ARB_W_ISSUE : ARB_R_ISSUE;
      ARB_W_ISSUE: if (i_wready)  w_next = ARB_W_WAIT;
      ARB_W_WAIT:  if (i_wdone)   w_next = ARB_IDLE;
      ARB_R_ISSUE: if (i_rready)  w_next = ARB_R_WAIT;
      ARB_R_WAIT:  if (i_rdone)   w_next = ARB_IDLE;
      default:                    w_next = ARB_IDLE;
    endcase
  end

  // Master-side payload: loaded on grant, held until reset or the next grant.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_grant  <= '0;
      r_last   <= IDX_W'(NUM_PORTS - 1);
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_wvalid <= 1'b0;
      r_raddr  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      if (w_start) begin
        r_grant <= w_gnt_idx;
        r_last  <= w_gnt_idx;
        if (r_kind_wr[w_gnt_idx]) begin
          r_waddr  <= w_line;
          r_wdata  <= w_wdata;
          r_wstrb  <= w_wstrb;
          r_wvalid <= 1'b1;
        end else begin
          r_raddr  <= w_line;
          r_rvalid <= 1'b1;
        end
      end
      if ((r_state == ARB_W_ISSUE) && i_wready) r_wvalid <= 1'b0;
      if ((r_state == ARB_R_ISSUE) && i_rready) r_rvalid <= 1'b0;
    end
  end

  // Per-port request slots; capture only happens on an idle port, so it never
  // collides with the grant or completion of that same port.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_busy    <= '0;
      r_pend    <= '0;
      r_kind_wr <= '0;
      r_addr    <= '0;
      r_din     <= '0;
      r_we      <= '0;
      r_dout    <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!r_busy[i] && ((|i_we[i]) || i_re[i])) begin
          r_busy[i]    <= 1'b1;
          r_pend[i]    <= 1'b1;
          r_kind_wr[i] <= |i_we[i];
          r_addr[i]    <= i_addr[i];
          r_din[i]     <= i_din[i];
          r_we[i]      <= i_we[i];
        end
        if (w_start && w_gnt_oh[i]) r_pend[i] <= 1'b0;
        if (w_fin && (r_grant == IDX_W'(i))) begin
          r_busy[i] <= 1'b0;
          if (r_state == ARB_R_WAIT) r_dout[i] <= w_rword;
        end
      end
    end
  end

  assign o_busy   = r_busy;
  assign o_dout   = r_dout;
  assign o_waddr  = r_waddr;
  assign o_wdata  = r_wdata;
  assign o_wstrb  = r_wstrb;
  assign o_wvalid = r_wvalid;
  assign o_raddr  = r_raddr;
  assign o_rvalid = r_rvalid;
endmodule

// File: tb/tb_rip_memory_port_arbiter.sv
// Bench for rip_memory_port_arbiter: directed scenarios plus random traffic,
// all outputs compared every cycle against a transaction-level model.
module tb_rip_memory_port_arbiter;
  import rip_const::*;
  localparam int NP = 3, AW = 32, DW = 32, LS = 16;
  localparam int BPW = DW / B_WIDTH, LW = LS * B_WIDTH;

  logic clk = 1'b0, rstn;
  logic [NP-1:0][BPW-1:0] we;
  logic [NP-1:0]          re;
  logic [NP-1:0][AW-1:0]  addr;
  logic [NP-1:0][DW-1:0]  din, dout;
  logic [NP-1:0]          busy;
  logic [AW-1:0]          waddr, raddr;
  logic [LW-1:0]          wdata, rdata;
  logic [LS-1:0]          wstrb;
  logic wvalid, wready, wdone, rvalid, rready, rdone;

  always #5 clk = ~clk;

  rip_memory_port_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_SIZE(LS)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_we(we), .i_re(re), .i_addr(addr), .i_din(din),
    .o_dout(dout), .o_busy(busy),
    .o_waddr(waddr), .o_wdata(wdata), .o_wstrb(wstrb), .o_wvalid(wvalid), .i_wready(wready), .i_wdone(wdone),
    .o_raddr(raddr), .o_rvalid(rvalid), .i_rready(rready), .i_rdata(rdata), .i_rdone(rdone)
  );

  // Model: per-port request record, one transaction in service (phase 0 none,
  // 1 offered to master, 2 awaiting done), expected output values.
  logic [NP-1:0] m_busy, m_pend, m_wr;
  logic [AW-1:0] m_addr [NP];
  logic [DW-1:0] m_din  [NP];
  logic [BPW-1:0] m_we  [NP];
  int m_cur, m_phase, m_last;
  logic [NP-1:0][DW-1:0] e_dout;
  logic [AW-1:0] e_waddr, e_raddr;
  logic [LW-1:0] e_wdata;
  logic [LS-1:0] e_wstrb;
  logic e_wvalid, e_rvalid;

  int n_chk = 0, n_err = 0;
  int order[$];

  function automatic void chk(string nm, logic [LW-1:0] act, logic [LW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic int woff(logic [AW-1:0] a);
    return int'(a % LS) / BPW;
  endfunction

  task automatic model_reset();
    m_busy = '0; m_pend = '0; m_wr = '0;
    m_cur = 0; m_phase = 0; m_last = NP - 1;
    for (int i = 0; i < NP; i++) begin m_addr[i] = '0; m_din[i] = '0; m_we[i] = '0; end
    e_dout = '0; e_waddr = '0; e_raddr = '0; e_wdata = '0; e_wstrb = '0;
    e_wvalid = 1'b0; e_rvalid = 1'b0;
  endtask

  task automatic model_step();
    logic [NP-1:0] ob;
    logic [LW-1:0] t;
    int ph;
    if (!rstn) begin model_reset(); return; end
    ob = m_busy; ph = m_phase;
    if (ph == 2) begin
      if (m_wr[m_cur] ? wdone : rdone) begin
        m_busy[m_cur] = 1'b0;
        if (!m_wr[m_cur]) begin
          t = rdata >> (DW * woff(m_addr[m_cur]));
          e_dout[m_cur] = t[DW-1:0];
        end
        m_phase = 0;
      end
    end else if (ph == 1) begin
      if (m_wr[m_cur] ? wready : rready) begin e_wvalid = 1'b0; e_rvalid = 1'b0; m_phase = 2; end
    end else begin
      for (int k = 1; k <= NP; k++) begin
        int p = (m_last + k) % NP;
        if (m_pend[p]) begin
          m_pend[p] = 1'b0; m_cur = p; m_last = p; m_phase = 1;
          if (m_wr[p]) begin
            e_waddr = m_addr[p] - (m_addr[p] % LS);
            e_wdata = LW'(m_din[p]) << (DW * woff(m_addr[p]));
            e_wstrb = LS'(m_we[p]) << (BPW * woff(m_addr[p]));
            e_wvalid = 1'b1;
          end else begin
            e_raddr = m_addr[p] - (m_addr[p] % LS);
            e_rvalid = 1'b1;
          end
          break;
        end
      end
    end
    for (int i = 0; i < NP; i++)
      if (!ob[i] && (we[i] != 0 || re[i])) begin
        m_busy[i] = 1'b1; m_pend[i] = 1'b1; m_wr[i] = (we[i] != 0);
        m_addr[i] = addr[i]; m_din[i] = din[i]; m_we[i] = we[i];
      end
  endtask

  always @(negedge clk) begin
    chk("busy",   LW'(busy),   LW'(m_busy));
    chk("dout",   LW'(dout),   LW'(e_dout));
    chk("wvalid", LW'(wvalid), LW'(e_wvalid));
    chk("waddr",  LW'(waddr),  LW'(e_waddr));
    chk("wdata",  wdata,       e_wdata);
    chk("wstrb",  LW'(wstrb),  LW'(e_wstrb));
    chk("rvalid", LW'(rvalid), LW'(e_rvalid));
    chk("raddr",  LW'(raddr),  LW'(e_raddr));
  end

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_in();
    we = '0; re = '0; wready = 0; rready = 0; wdone = 0; rdone = 0;
  endtask

  task automatic chk_all_zero(string nm);
    chk({nm, "_busy"}, LW'(busy), '0);
    chk({nm, "_dout"}, LW'(dout), '0);
    chk({nm, "_wv"},   LW'({wvalid, rvalid}), '0);
    chk({nm, "_wa"},   LW'({waddr, raddr, wstrb}), '0);
    chk({nm, "_wd"},   wdata, '0);
  endtask

  initial begin
    int cnt[NP];
    logic pw;
    rstn = 1'b0; idle_in(); addr = '0; din = '0; rdata = '0;
    model_reset();
    repeat (2) cyc();
    chk_all_zero("reset");
    rstn = 1'b1;

    // Single read, word 2 of a 16-byte line.
    re[0] = 1; addr[0] = 32'h0000_1008; rready = 1;
    cyc(); re[0] = 0; addr[0] = 32'h5555_5555;
    chk("rd_busy_e0", LW'(busy[0]), 1);
    cyc();
    chk("rd_rvalid", LW'(rvalid), 1); chk("rd_raddr", LW'(raddr), 32'h0000_1000);
    chk("rd_busy_e1", LW'(busy[0]), 1);
    cyc();
    chk("rd_rvalid_drop", LW'(rvalid), 0); chk("rd_busy_e2", LW'(busy[0]), 1);
    rdone = 1; rdata = {32'h1111_1111, 32'hDEAD_BEEF, 32'h2222_2222, 32'h3333_3333};
    cyc(); rdone = 0; rready = 0;
    chk("rd_dout", LW'(dout[0]), 32'hDEAD_BEEF); chk("rd_busy_done", LW'(busy[0]), 0);

    // Byte write on port 1, word offset 1.
    we[1] = 4'b0100; din[1] = 32'h00AB_0000; addr[1] = 32'h0000_0004; wready = 1;
    cyc(); we[1] = '0;
    cyc();
    chk("wr_wvalid", LW'(wvalid), 1); chk("wr_wstrb", LW'(wstrb), 16'h0040);
    chk("wr_wdata", wdata, 128'h00000000_00000000_00AB0000_00000000);
    chk("wr_waddr", LW'(waddr), 0);
    cyc(); chk("wr_wvalid_drop", LW'(wvalid), 0);
    wdone = 1; cyc(); wdone = 0; wready = 0;
    chk("wr_busy_done", LW'(busy[1]), 0);

    // Backpressure on port 2 write: payload must hold while wready is low.
    we[2] = 4'hF; din[2] = 32'hCAFE_F00D; addr[2] = 32'h0000_002C;
    cyc(); we[2] = '0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk("bp_wvalid", LW'(wvalid), 1); chk("bp_waddr", LW'(waddr), 32'h20);
      chk("bp_wdata", wdata, 128'hCAFEF00D_00000000_00000000_00000000);
      chk("bp_wstrb", LW'(wstrb), 16'hF000);
      cyc();
    end
    wready = 1; cyc();
    chk("bp_wvalid_drop", LW'(wvalid), 0);
    wready = 0; wdone = 1; cyc(); wdone = 0;

    // Busy-port ignore: second request with new address is dropped.
    re[0] = 1; addr[0] = 32'h0000_2000;
    cyc(); addr[0] = 32'h0000_3000;
    cyc(); re[0] = 0;
    chk("ign_raddr", LW'(raddr), 32'h2000); chk("ign_rvalid", LW'(rvalid), 1);
    rready = 1; cyc(); rready = 0;
    rdone = 1; rdata = {4{32'h7777_0000}}; cyc(); rdone = 0;
    repeat (3) begin
      cyc(); chk("ign_no_reissue", LW'(rvalid), 0); chk("ign_idle", LW'(busy[0]), 0);
    end

    // Reset while a read is outstanding in the wait phase.
    re[1] = 1; addr[1] = 32'h0000_0040; rready = 1;
    cyc(); re[1] = 0; cyc(); cyc();
    chk("rst_pre_rvalid", LW'(rvalid), 0); chk("rst_pre_busy", LW'(busy[1]), 1);
    rstn = 0; rready = 0; cyc();
    chk_all_zero("rst_mid");
    rstn = 1; rdone = 1; rdata = {4{32'h1234_5678}}; cyc(); rdone = 0;
    chk("rst_dout_kept", LW'(dout), '0); chk("rst_busy_kept", LW'(busy), '0);

    // Contention: all three ports, two rounds, starting from reset.
    rstn = 0; cyc(); rstn = 1;
    wready = 1; wdone = 1; pw = 1'b0;
    for (int i = 0; i < NP; i++) cnt[i] = 0;
    for (int c = 0; c < 200 && order.size() < 6; c++) begin
      for (int p = 0; p < NP; p++)
        if (!m_busy[p] && cnt[p] < 2) begin
          we[p] = 4'hF; addr[p] = 32'h100 * (p + 1); din[p] = DW'(p); cnt[p]++;
        end else we[p] = '0;
      cyc();
      if (wvalid && !pw) order.push_back(int'(waddr >> 8) - 1);
      pw = wvalid;
    end
    chk("cont_count", LW'(order.size()), 6);
    for (int i = 0; i < order.size(); i++) chk("cont_order", LW'(order[i]), LW'(i % NP));
    idle_in(); repeat (4) cyc();

    // Random traffic with random master handshakes and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      rstn = ($urandom_range(0, 599) != 0);
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 2) == 0) begin
          we[p] = $urandom_range(0, 1) ? BPW'($urandom) : '0;
          re[p] = 1'($urandom_range(0, 1));
          addr[p] = $urandom; din[p] = $urandom;
        end else begin
          we[p] = '0; re[p] = 1'b0;
        end
      end
      wready = 1'($urandom_range(0, 1)); rready = 1'($urandom_range(0, 1));
      wdone = ($urandom_range(0, 2) == 0); rdone = ($urandom_range(0, 2) == 0);
      rdata = {$urandom, $urandom, $urandom, $urandom};
      cyc();
    end
    rstn = 1; idle_in(); wready = 1; rready = 1; wdone = 1; rdone = 1;
    for (int c = 0; c < 50 && m_busy != 0; c++) cyc();
    chk("drain_idle", LW'(busy), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
